// File: rtl/l2sw_pkg.sv
// Shared L2 switch simulator types: frame layout {SFD, DST, SRC, PAYLOAD},
// MAC constants and the receive-log entry format.
package l2sw_pkg;

    localparam logic [3:0] SFD   = 4'b0101;
    localparam logic [3:0] MAC_A = 4'hA;
    localparam logic [3:0] MAC_B = 4'hB;
    localparam logic [3:0] MAC_C = 4'hC;
    localparam logic [3:0] MAC_D = 4'hD;

    localparam int unsigned FIELD_W = 4;
    localparam int unsigned SFD_LSB = 12;
    localparam int unsigned DST_LSB = 8;
    localparam int unsigned SRC_LSB = 4;
    localparam int unsigned PAY_LSB = 0;

    typedef logic [15:0] frame_t;

    typedef struct packed {
        logic [1:0] port;
        frame_t     frame;
    } log_entry_t;

    function automatic logic [FIELD_W-1:0] frame_field(input frame_t f, input int unsigned lsb);
        return f[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/rx_frame_logger_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         FPGA_CLK,
    input  logic         sys_rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      idx;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                if (advance) begin
                    ptr_d = PTR_W'((idx + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rx_frame_logger.sv
// Receive-side frame logger: captures end-device frames into an append-only
// browsable log. Optional SFD rejection is enabled by RXLOG_SFD_CHECK_EN.
module rx_frame_logger
    import l2sw_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 8,
    parameter int FRAME_W   = 16
) (
    input  logic                         FPGA_CLK,
    input  logic                         sys_rst,
    input  logic [NUM_PORTS*FRAME_W-1:0] rx_frame_flat,
    input  logic [NUM_PORTS-1:0]         frame_rx_valid,
    input  logic                         clear,
    input  logic                         next_btn,
    output logic                         sel_valid,
    output logic [3:0]                   sel_index,
    output logic [1:0]                   sel_port,
    output logic [3:0]                   sel_dst,
    output logic [3:0]                   sel_src,
    output logic [3:0]                   sel_payload,
    output logic [4:0]                   log_count,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef RXLOG_SFD_CHECK_EN
    localparam bit SFD_CHECK = 1'b1;
`else
    localparam bit SFD_CHECK = 1'b0;
`endif

    logic [NUM_PORTS-1:0] v_d1_q, v_d1_d;
    logic                 btn_d1_q, btn_d1_d;
    logic [NUM_PORTS-1:0] slot_full_q, slot_full_d;
    frame_t               slot_frame_q [NUM_PORTS];
    frame_t               slot_frame_d [NUM_PORTS];
    log_entry_t           mem_q [DEPTH];
    log_entry_t           mem_d [DEPTH];
    logic [4:0]           log_count_q, log_count_d;
    logic [3:0]           view_idx_q, view_idx_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_count_q, drop_count_d;

    logic                 sel_valid_q, sel_valid_d;
    logic [3:0]           sel_index_q, sel_index_d;
    logic [1:0]           sel_port_q, sel_port_d;
    logic [3:0]           sel_dst_q, sel_dst_d;
    logic [3:0]           sel_src_q, sel_src_d;
    logic [3:0]           sel_payload_q, sel_payload_d;

    logic [NUM_PORTS-1:0] arrival;
    logic [NUM_PORTS-1:0] grant;
    logic [1:0]           gnt_port;
    frame_t               in_frame;
    logic [3:0]           drops;
    logic [8:0]           drop_sum;
    logic                 sfd_bad;
    logic [IDX_W-1:0]     view_rd;

    assign arrival = frame_rx_valid & ~v_d1_q;

    rr_arbiter #(
        .N(NUM_PORTS)
    ) u_arb (
        .FPGA_CLK (FPGA_CLK),
        .sys_rst  (sys_rst),
        .req      (slot_full_q),
        .advance  (~clear),
        .grant    (grant)
    );

    always_comb begin
        v_d1_d       = frame_rx_valid;
        btn_d1_d     = next_btn;
        slot_full_d  = slot_full_q;
        slot_frame_d = slot_frame_q;
        mem_d        = mem_q;
        log_count_d  = log_count_q;
        view_idx_d   = view_idx_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        drops        = '0;
        gnt_port     = '0;
        in_frame     = '0;
        sfd_bad      = 1'b0;
        drop_sum     = '0;

        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                gnt_port       = 2'(p);
                slot_full_d[p] = 1'b0;
            end
        end

        // A granted slot frees up this cycle, so an arrival there reloads it rather than dropping.
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            in_frame = frame_t'(rx_frame_flat[p*FRAME_W +: FRAME_W]);
            sfd_bad  = SFD_CHECK && (frame_field(in_frame, SFD_LSB) != SFD);
            if (arrival[p]) begin
                if (sfd_bad || (slot_full_q[p] && !grant[p])) begin
                    drops = drops + 4'd1;
                end else begin
                    slot_full_d[p]  = 1'b1;
                    slot_frame_d[p] = in_frame;
                end
            end
        end

        if (|grant) begin
            if (log_count_q == 5'(DEPTH)) begin
                drops = drops + 4'd1;
            end else begin
                mem_d[log_count_q[IDX_W-1:0]] = {gnt_port, slot_frame_q[gnt_port]};
                log_count_d = log_count_q + 5'd1;
            end
        end

        drop_sum     = {1'b0, drop_count_q} + 9'(drops);
        drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (drops != '0) begin
            overflow_d = 1'b1;
        end

        if (next_btn && !btn_d1_q && (log_count_q != '0)) begin
            if ({1'b0, view_idx_q} == log_count_q - 5'd1) begin
                view_idx_d = '0;
            end else begin
                view_idx_d = view_idx_q + 4'd1;
            end
        end

        if (clear) begin
            slot_full_d  = '0;
            mem_d        = mem_q;
            log_count_d  = '0;
            view_idx_d   = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    assign view_rd = view_idx_q[IDX_W-1:0];

    always_comb begin
        sel_valid_d   = (log_count_q != '0);
        sel_index_d   = '0;
        sel_port_d    = '0;
        sel_dst_d     = '0;
        sel_src_d     = '0;
        sel_payload_d = '0;
        if (sel_valid_d) begin
            sel_index_d   = view_idx_q;
            sel_port_d    = mem_q[view_rd].port;
            sel_dst_d     = frame_field(mem_q[view_rd].frame, DST_LSB);
            sel_src_d     = frame_field(mem_q[view_rd].frame, SRC_LSB);
            sel_payload_d = frame_field(mem_q[view_rd].frame, PAY_LSB);
        end
    end

    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            v_d1_q        <= '0;
            btn_d1_q      <= 1'b0;
            slot_full_q   <= '0;
            slot_frame_q  <= '{default: '0};
            log_count_q   <= '0;
            view_idx_q    <= '0;
            overflow_q    <= 1'b0;
            drop_count_q  <= '0;
            sel_valid_q   <= 1'b0;
            sel_index_q   <= '0;
            sel_port_q    <= '0;
            sel_dst_q     <= '0;
            sel_src_q     <= '0;
            sel_payload_q <= '0;
        end else begin
            v_d1_q        <= v_d1_d;
            btn_d1_q      <= btn_d1_d;
            slot_full_q   <= slot_full_d;
            slot_frame_q  <= slot_frame_d;
            log_count_q   <= log_count_d;
            view_idx_q    <= view_idx_d;
            overflow_q    <= overflow_d;
            drop_count_q  <= drop_count_d;
            sel_valid_q   <= sel_valid_d;
            sel_index_q   <= sel_index_d;
            sel_port_q    <= sel_port_d;
            sel_dst_q     <= sel_dst_d;
            sel_src_q     <= sel_src_d;
            sel_payload_q <= sel_payload_d;
        end
    end

    // Log storage carries no reset; entries beyond log_count are never displayed.
    always_ff @(posedge FPGA_CLK) begin
        mem_q <= mem_d;
    end

    assign sel_valid   = sel_valid_q;
    assign sel_index   = sel_index_q;
    assign sel_port    = sel_port_q;
    assign sel_dst     = sel_dst_q;
    assign sel_src     = sel_src_q;
    assign sel_payload = sel_payload_q;
    assign log_count   = log_count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

endmodule
